// File: rtl/fnv_pkg.sv
// Shared types and constants for the FNV-1a hasher and its byte-serial read-back path.
package fnv_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } tx_state_e;

  localparam logic [31:0] FNV_OFFSET_BASIS = 32'h811C9DC5;
  localparam logic [31:0] FNV_PRIME        = 32'h01000193;
  localparam int unsigned HASH_BYTES       = 4;

  // XOR of the four bytes of a 32-bit word; used as the frame checksum byte.
  function automatic logic [7:0] xor_fold32(input logic [31:0] v);
    return v[31:24] ^ v[23:16] ^ v[15:8] ^ v[7:0];
  endfunction

endpackage

// File: rtl/fnv_hash_tx.sv
// Snapshots a 32-bit hash on start and streams it out as bytes over valid/ready.
// Define HASH_TX_CHECKSUM_EN to append an XOR checksum byte to every frame.
module fnv_hash_tx
  import fnv_pkg::*;
#(
  parameter bit          MsbFirst  = 1'b1,
  parameter int unsigned HashBytes = HASH_BYTES
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] hash_in,
  input  logic        start,
  input  logic        abort,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        busy,
  output logic        done
);

`ifdef HASH_TX_CHECKSUM_EN
  localparam int unsigned FrameBytes = HashBytes + 1;
`else
  localparam int unsigned FrameBytes = HashBytes;
`endif
  localparam int unsigned ShW     = 8 * FrameBytes;
  localparam logic [2:0]  LastIdx = 3'(FrameBytes - 1);

  tx_state_e        state_q, state_d;
  logic [ShW-1:0]   sh_q, sh_d;
  logic [2:0]       cnt_q, cnt_d;
  logic [ShW-1:0]   load_c;
  logic [7:0]       head_c;

  // Frame image laid out so the first byte to send sits at the outgoing end.
`ifdef HASH_TX_CHECKSUM_EN
  assign load_c = MsbFirst ? ShW'({hash_in, xor_fold32(hash_in)})
                           : ShW'({xor_fold32(hash_in), hash_in});
`else
  assign load_c = ShW'(hash_in);
`endif

  assign head_c = MsbFirst ? sh_q[ShW-1 -: 8] : sh_q[7:0];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sh_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (start && !abort) begin
          sh_d    = load_c;
          cnt_d   = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        // A transfer coinciding with abort still consumes the byte.
        if (tx_ready) begin
          sh_d  = MsbFirst ? (sh_q << 8) : (sh_q >> 8);
          cnt_d = cnt_q + 3'd1;
          if (cnt_q == LastIdx) state_d = DONE;
        end
        if (abort) state_d = IDLE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign tx_valid = (state_q == SEND);
  assign tx_data  = tx_valid ? head_c : 8'h00;
  assign busy     = (state_q != IDLE);
  assign done     = (state_q == DONE);

endmodule

// File: tb/tb_fnv_hash_tx.sv
// Randomized bench for fnv_hash_tx: MSB-first and LSB-first instances vs a byte-queue model.
module tb_fnv_hash_tx;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] hash_in;
  logic        start, abort, tx_ready;
  logic [7:0]  data_m, data_l;
  logic        valid_m, valid_l, busy_m, busy_l, done_m, done_l;

  int checks   = 0;
  int failures = 0;

  logic [7:0] q_m[$];
  logic [7:0] q_l[$];
  bit         pend_done;

  always #5 clk = ~clk;

  fnv_hash_tx #(.MsbFirst(1'b1)) u_msb (
    .clk(clk), .rst_n(rst_n), .hash_in(hash_in), .start(start), .abort(abort),
    .tx_data(data_m), .tx_valid(valid_m), .tx_ready(tx_ready), .busy(busy_m), .done(done_m)
  );

  fnv_hash_tx #(.MsbFirst(1'b0)) u_lsb (
    .clk(clk), .rst_n(rst_n), .hash_in(hash_in), .start(start), .abort(abort),
    .tx_data(data_l), .tx_valid(valid_l), .tx_ready(tx_ready), .busy(busy_l), .done(done_l)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Build the expected byte list for a frame from the captured hash.
  task automatic load_frame(input logic [31:0] h);
    logic [7:0] b;
    logic [7:0] cks;
    cks = 8'h00;
    q_m.delete();
    q_l.delete();
    for (int i = 0; i < 4; i++) begin
      b = 8'((h >> (24 - 8 * i)) & 32'hFF);
      q_m.push_back(b);
      cks = cks ^ b;
      q_l.push_back(8'((h >> (8 * i)) & 32'hFF));
    end
`ifdef HASH_TX_CHECKSUM_EN
    q_m.push_back(cks);
    q_l.push_back(cks);
`endif
  endtask

  task automatic model_step(input logic rs, input logic st, input logic ab,
                            input logic rd, input logic [31:0] h);
    logic [7:0] dummy;
    if (!rs) begin
      q_m.delete();
      q_l.delete();
      pend_done = 1'b0;
    end else if (q_m.size() != 0 || pend_done) begin
      if (pend_done) begin
        pend_done = 1'b0;
      end else if (rd) begin
        dummy = q_m.pop_front();
        dummy = q_l.pop_front();
        if (q_m.size() == 0) pend_done = 1'b1;
      end
      if (ab) begin
        q_m.delete();
        q_l.delete();
        pend_done = 1'b0;
      end
    end else if (st && !ab) begin
      load_frame(h);
    end
  endtask

  task automatic check_outputs();
    logic       ev;
    logic [7:0] em, el;
    ev = (q_m.size() != 0);
    em = ev ? q_m[0] : 8'h00;
    el = ev ? q_l[0] : 8'h00;
    check_eq("msb_valid", 32'(valid_m), 32'(ev));
    check_eq("msb_data",  32'(data_m),  32'(em));
    check_eq("msb_busy",  32'(busy_m),  32'(ev || pend_done));
    check_eq("msb_done",  32'(done_m),  32'(pend_done));
    check_eq("lsb_valid", 32'(valid_l), 32'(ev));
    check_eq("lsb_data",  32'(data_l),  32'(el));
    check_eq("lsb_busy",  32'(busy_l),  32'(ev || pend_done));
    check_eq("lsb_done",  32'(done_l),  32'(pend_done));
  endtask

  task automatic cycle(input logic st, input logic ab, input logic rd);
    start    = st;
    abort    = ab;
    tx_ready = rd;
    @(posedge clk);
    model_step(rst_n, st, ab, rd, hash_in);
    #1;
    check_outputs();
  endtask

  initial begin
    logic [6:0] pat;
    rst_n = 1'b0; hash_in = 32'h0; start = 1'b0; abort = 1'b0; tx_ready = 1'b0;
    pend_done = 1'b0;
    #1;
    cycle(1'b1, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;

    // Back-to-back frame with the consumer always ready.
    hash_in = 32'hE40C292C;
    cycle(1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 7; i++) cycle(1'b0, 1'b0, 1'b1);

    // Stalled consumer: data must hold while not ready.
    pat = 7'b1101001;
    cycle(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) cycle(1'b0, 1'b0, pat[i]);
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 1'b1);

    // Offset basis, plus start mid-frame with a changed hash_in ignored.
    hash_in = 32'h811C9DC5;
    cycle(1'b1, 1'b0, 1'b1);
    hash_in = 32'hDEADBEEF;
    cycle(1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0, 1'b1);

    // Abort after two bytes, then a fresh frame.
    hash_in = 32'hE40C292C;
    cycle(1'b1, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b1);
    cycle(1'b0, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 1'b1);
    hash_in = 32'h00000001;
    cycle(1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 7; i++) cycle(1'b1, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b1);

    // Abort together with start in idle: nothing starts.
    cycle(1'b1, 1'b1, 1'b1);
    cycle(1'b0, 1'b0, 1'b1);

    // Abort on the final transfer: no done pulse.
    hash_in = 32'h12345678;
    cycle(1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b1);
`ifdef HASH_TX_CHECKSUM_EN
    cycle(1'b0, 1'b0, 1'b1);
`endif
    cycle(1'b0, 1'b1, 1'b1);
    cycle(1'b0, 1'b0, 1'b1);

    // Reset mid-frame drops everything.
    cycle(1'b1, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b0);
    rst_n = 1'b0;
    cycle(1'b0, 1'b0, 1'b1);
    rst_n = 1'b1;
    cycle(1'b0, 1'b0, 1'b1);

    // Random traffic: sporadic start/abort/reset, changing hash_in.
    for (int n = 0; n < 3000; n++) begin
      hash_in = $urandom;
      rst_n   = ($urandom_range(0, 199) != 0);
      cycle(($urandom_range(0, 5) == 0), ($urandom_range(0, 24) == 0), ($urandom_range(0, 1) == 1));
    end
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) cycle(1'b0, 1'b0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fnv_hash_tx.md
Name: fnv_hash_tx

Overview:
Read-back path for the FNV-1a hasher. Snapshots a 32-bit hash value on command and serializes it as a byte stream over a valid/ready handshake to the I2C target's read-data path. It is the outbound counterpart to the byte-in/hash-out hasher: bytes go in to the hasher, and this block sends the hash back out as bytes.

Parameters:
MsbFirst, 1, 1 = byte 0 sent is hash[31:24]; 0 = byte 0 sent is hash[7:0]
HashBytes, 4, number of data bytes sent per frame; fixed at 4 for the 32-bit hash

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous active-low reset
hash_in  input  32  current hasher output; sampled only on an accepted start
start  input  1  single-cycle request: capture hash_in and begin a frame
abort  input  1  terminate the current frame immediately (I2C STOP or NACK)
tx_data  output  8  byte presented to the consumer
tx_valid  output  1  tx_data is valid
tx_ready  input  1  consumer accepts tx_data this cycle
busy  output  1  frame in progress (SEND or DONE)
done  output  1  one-cycle pulse after the final byte is accepted

Behaviour:
- Reset (rst_n=0 at a clk edge): state=IDLE; tx_valid=0, tx_data=8'h00, busy=0, done=0; shift register=0; byte counter=0. Reset mid-frame drops the frame silently.
- States: IDLE, SEND, DONE.
- IDLE: start=1 -> capture hash_in into the shift register, counter=0, go to SEND. tx_valid=1 and tx_data=byte 0 appear on the next cycle (1-cycle latency). busy rises in the same cycle.
- SEND, handshake: a byte transfers on a clk edge where tx_valid&&tx_ready.
  - tx_data must hold stable while tx_valid=1 and tx_ready=0.
  - tx_valid stays high between bytes: a back-to-back transfer every cycle is allowed.
  - On a transfer, the shift register advances by 8 bits (direction per MsbFirst) and the counter increments.
  - On transfer of the last byte: go to DONE, tx_valid=0 next cycle.
- DONE: done=1 and busy=1 for exactly one cycle, then IDLE.
- start outside IDLE is ignored and causes no recapture. hash_in changing during a frame has no effect.
- abort=1 in SEND or DONE: next cycle state=IDLE, tx_valid=0, busy=0, no done pulse.
  - Abort takes priority over a simultaneous final-byte transfer: the byte counts as consumed, but done is not pulsed.
  - abort in IDLE is a no-op. abort and start together in IDLE: abort wins, and no frame starts.
- tx_data when tx_valid=0 is don't-care functionally, but the implementation drives 8'h00.
- The counter is 3 bits wide and never wraps within a frame. The final byte index is HashBytes-1, or HashBytes when the checksum feature is enabled.

Optional Feature:
Macro HASH_TX_CHECKSUM_EN.
- Defined: the frame carries HashBytes+1 bytes. The extra last byte is the XOR of the 4 hash bytes, computed at capture time. done pulses after the checksum byte is accepted.
- Undefined: the frame is exactly 4 bytes, no checksum logic is present, and counter compares use HashBytes-1.

Decomposition:
- Package fnv_pkg holds:
  - enum tx_state_e {IDLE, SEND, DONE}
  - localparams FNV_OFFSET_BASIS=32'h811C9DC5, FNV_PRIME=32'h01000193, HASH_BYTES=4
  - function xor_fold32 (32-bit in, 8-bit out), used for the checksum
- No sub-module. A single always_ff for state, shift register and counter; combinational output decode.

Test Plan:
1. Reset, then start with hash_in=32'hE40C292C and tx_ready held at 1 -> tx_data E4,0C,29,2C on 4 consecutive cycles; done pulses on the cycle after 2C; busy low afterwards.
2. Same hash, tx_ready toggling 1,0,0,1,0,1,1 -> tx_data holds stable while stalled; byte order E4,0C,29,2C unchanged; exactly one done.
3. MsbFirst=0, hash_in=32'h811C9DC5 -> bytes C5,9D,1C,81.
4. Abort after 2 accepted bytes, then start with 32'h00000001 -> no done for the first frame; second frame sends 00,00,00,01. Also: start pulsed mid-frame is ignored.
5. Abort on the same cycle as the final transfer -> no done pulse; state IDLE next cycle. rst_n=0 mid-frame -> all outputs 0 next cycle.
6. HASH_TX_CHECKSUM_EN defined, hash 32'hE40C292C -> bytes E4,0C,29,2C,ED; done pulses after ED.
